// File: rtl/id_ex_operand_stage_pkg.sv
// rtl/id_ex_operand_stage_pkg.sv - shared constants and update-command type for the ID/EX stage
package id_ex_operand_stage_pkg;

    localparam int DW_DEF = 32;
    localparam int AW_DEF = 5;
    localparam int TW_DEF = 2;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [4:0]  REG_ZERO  = 5'd0;
    localparam logic [1:0]  TNEW_ZERO = 2'd0;

    typedef enum logic [1:0] {
        UPD_LOAD = 2'd0,
        UPD_HOLD = 2'd1,
        UPD_NOP  = 2'd2
    } upd_e;

    // Flush beats hold so a killed instruction never survives a stall.
    function automatic upd_e upd_select(input logic flush, input logic hold, input logic bubble);
        if (flush) begin
            return UPD_NOP;
        end else if (hold) begin
            return UPD_HOLD;
        end else if (bubble) begin
            return UPD_NOP;
        end
        return UPD_LOAD;
    endfunction

endpackage

// File: rtl/operand_fwd_mux.sv
// rtl/operand_fwd_mux.sv - per-operand MEM/WB forwarding select for the E stage
module operand_fwd_mux #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic [AW-1:0] r,
    input  logic [DW-1:0] captured,
    input  logic          m_we,
    input  logic [AW-1:0] m_addr,
    input  logic [DW-1:0] m_data,
    input  logic          w_we,
    input  logic [AW-1:0] w_addr,
    input  logic [DW-1:0] w_data,
    output logic [DW-1:0] value
);

    // $zero reads as 0 whatever a producer claims to write there.
    always_comb begin
        value = captured;
        if (r == '0) begin
            value = '0;
        end else if (m_we && (m_addr == r)) begin
            value = m_data;
        end else if (w_we && (w_addr == r)) begin
            value = w_data;
        end
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// rtl/id_ex_operand_stage.sv - ID/EX pipeline register with hold refresh and operand forwarding
module id_ex_operand_stage
    import id_ex_operand_stage_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF,
    parameter int TW = TW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          hold_i,
    input  logic          bubble_i,
    input  logic          flush_i,
    input  logic          id_valid,
    input  logic [DW-1:0] id_pc,
    input  logic [DW-1:0] id_instr,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic [AW-1:0] id_dst,
    input  logic [DW-1:0] id_rd1,
    input  logic [DW-1:0] id_rd2,
    input  logic [DW-1:0] id_imm,
    input  logic [TW-1:0] id_tnew,
    input  logic          m_we,
    input  logic [AW-1:0] m_addr,
    input  logic [DW-1:0] m_data,
    input  logic          w_we,
    input  logic [AW-1:0] w_addr,
    input  logic [DW-1:0] w_data,
    output logic          ex_valid,
    output logic [DW-1:0] ex_pc,
    output logic [DW-1:0] ex_instr,
    output logic [AW-1:0] ex_rs,
    output logic [AW-1:0] ex_rt,
    output logic [AW-1:0] ex_dst,
    output logic [DW-1:0] ex_imm,
    output logic [DW-1:0] ex_rs_val,
    output logic [DW-1:0] ex_rt_val,
    output logic [TW-1:0] ex_tnew
);

    upd_e          upd;
    logic [DW-1:0] rs_cap;
    logic [DW-1:0] rt_cap;
    logic          rs_wb_hit;
    logic          rt_wb_hit;
    logic [TW-1:0] tnew_next;

    always_comb begin
        upd = upd_select(flush_i, hold_i, bubble_i);
    end

    // A WB write landing while E is frozen must end up in the captured copy,
    // otherwise the value would go stale once WB moves on.
    assign rs_wb_hit = w_we && (w_addr == ex_rs) && (ex_rs != '0);
    assign rt_wb_hit = w_we && (w_addr == ex_rt) && (ex_rt != '0);

    assign tnew_next = (id_tnew == '0) ? '0 : id_tnew - 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid <= 1'b0;
            ex_pc    <= '0;
            ex_instr <= '0;
            ex_rs    <= '0;
            ex_rt    <= '0;
            ex_dst   <= '0;
            ex_imm   <= '0;
            rs_cap   <= '0;
            rt_cap   <= '0;
            ex_tnew  <= '0;
        end else begin
            case (upd)
                UPD_LOAD: begin
                    ex_valid <= id_valid;
                    ex_pc    <= id_pc;
                    ex_instr <= id_instr;
                    ex_rs    <= id_rs;
                    ex_rt    <= id_rt;
                    ex_dst   <= id_valid ? id_dst : '0;
                    ex_imm   <= id_imm;
                    rs_cap   <= id_rd1;
                    rt_cap   <= id_rd2;
                    ex_tnew  <= tnew_next;
                end
                UPD_HOLD: begin
                    if (rs_wb_hit) begin
                        rs_cap <= w_data;
                    end
                    if (rt_wb_hit) begin
                        rt_cap <= w_data;
                    end
                end
                default: begin
                    ex_valid <= 1'b0;
                    ex_pc    <= '0;
                    ex_instr <= '0;
                    ex_rs    <= '0;
                    ex_rt    <= '0;
                    ex_dst   <= '0;
                    ex_imm   <= '0;
                    rs_cap   <= '0;
                    rt_cap   <= '0;
                    ex_tnew  <= '0;
                end
            endcase
        end
    end

    operand_fwd_mux #(.DW(DW), .AW(AW)) u_fwd_rs (
        .r        (ex_rs),
        .captured (rs_cap),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_data   (m_data),
        .w_we     (w_we),
        .w_addr   (w_addr),
        .w_data   (w_data),
        .value    (ex_rs_val)
    );

    operand_fwd_mux #(.DW(DW), .AW(AW)) u_fwd_rt (
        .r        (ex_rt),
        .captured (rt_cap),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_data   (m_data),
        .w_we     (w_we),
        .w_addr   (w_addr),
        .w_data   (w_data),
        .value    (ex_rt_val)
    );

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb/tb_id_ex_operand_stage.sv - self-checking bench for id_ex_operand_stage
module tb_id_ex_operand_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        hold_i, bubble_i, flush_i, id_valid;
    logic [31:0] id_pc, id_instr, id_rd1, id_rd2, id_imm;
    logic [4:0]  id_rs, id_rt, id_dst;
    logic [1:0]  id_tnew;
    logic        m_we, w_we;
    logic [4:0]  m_addr, w_addr;
    logic [31:0] m_data, w_data;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_instr, ex_imm, ex_rs_val, ex_rt_val;
    logic [4:0]  ex_rs, ex_rt, ex_dst;
    logic [1:0]  ex_tnew;

    int checks = 0;
    int errors = 0;

    // Reference E-stage contents
    logic        e_valid;
    logic [31:0] e_pc, e_instr, e_imm, e_rs_cap, e_rt_cap;
    logic [4:0]  e_rs, e_rt, e_dst;
    int          e_tnew;

    always #5 clk = ~clk;

    id_ex_operand_stage dut (
        .clk(clk), .reset(reset), .hold_i(hold_i), .bubble_i(bubble_i), .flush_i(flush_i),
        .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr), .id_rs(id_rs), .id_rt(id_rt),
        .id_dst(id_dst), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_tnew(id_tnew),
        .m_we(m_we), .m_addr(m_addr), .m_data(m_data), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_instr(ex_instr), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_dst(ex_dst), .ex_imm(ex_imm), .ex_rs_val(ex_rs_val), .ex_rt_val(ex_rt_val), .ex_tnew(ex_tnew)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] cap);
        if (r == 0) return 32'h0;
        if (m_we && m_addr == r) return m_data;
        if (w_we && w_addr == r) return w_data;
        return cap;
    endfunction

    task automatic model_clear();
        e_valid = 0; e_pc = 0; e_instr = 0; e_imm = 0; e_rs_cap = 0; e_rt_cap = 0;
        e_rs = 0; e_rt = 0; e_dst = 0; e_tnew = 0;
    endtask

    task automatic model_edge();
        if (flush_i) begin
            model_clear();
        end else if (hold_i) begin
            if (w_we && w_addr == e_rs && e_rs != 0) e_rs_cap = w_data;
            if (w_we && w_addr == e_rt && e_rt != 0) e_rt_cap = w_data;
        end else if (bubble_i) begin
            model_clear();
        end else begin
            e_valid = id_valid; e_pc = id_pc; e_instr = id_instr; e_imm = id_imm;
            e_rs = id_rs; e_rt = id_rt; e_dst = id_valid ? id_dst : 5'd0;
            e_rs_cap = id_rd1; e_rt_cap = id_rd2;
            e_tnew = (int'(id_tnew) == 0) ? 0 : int'(id_tnew) - 1;
        end
    endtask

    task automatic check_all(input string ph);
        chk({ph, ".valid"}, 32'(ex_valid), 32'(e_valid));
        chk({ph, ".pc"}, ex_pc, e_pc);
        chk({ph, ".instr"}, ex_instr, e_instr);
        chk({ph, ".rs"}, 32'(ex_rs), 32'(e_rs));
        chk({ph, ".rt"}, 32'(ex_rt), 32'(e_rt));
        chk({ph, ".dst"}, 32'(ex_dst), 32'(e_dst));
        chk({ph, ".imm"}, ex_imm, e_imm);
        chk({ph, ".tnew"}, 32'(ex_tnew), 32'(e_tnew));
        chk({ph, ".rs_val"}, ex_rs_val, fwd(e_rs, e_rs_cap));
        chk({ph, ".rt_val"}, ex_rt_val, fwd(e_rt, e_rt_cap));
    endtask

    task automatic step(input string ph);
        @(posedge clk);
        model_edge();
        #1;
        check_all(ph);
    endtask

    task automatic clear_in();
        hold_i = 0; bubble_i = 0; flush_i = 0; id_valid = 0;
        id_pc = 0; id_instr = 0; id_rs = 0; id_rt = 0; id_dst = 0;
        id_rd1 = 0; id_rd2 = 0; id_imm = 0; id_tnew = 0;
        m_we = 0; m_addr = 0; m_data = 0; w_we = 0; w_addr = 0; w_data = 0;
    endtask

    task automatic load_instr(input logic [31:0] pc, input logic [31:0] instr, input logic [4:0] rs,
                              input logic [4:0] rt, input logic [4:0] dst, input logic [31:0] rd1,
                              input logic [31:0] rd2, input logic [1:0] tn);
        id_valid = 1; id_pc = pc; id_instr = instr; id_rs = rs; id_rt = rt; id_dst = dst;
        id_rd1 = rd1; id_rd2 = rd2; id_imm = 32'h10; id_tnew = tn;
    endtask

    initial begin
        clear_in();
        model_clear();
        reset = 0;
        #12;
        check_all("reset");
        @(negedge clk);
        reset = 1;

        // addu $3,$1,$2
        load_instr(32'h3000, 32'h0022_1821, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 2'd2);
        step("addu");
        chk("addu_dst", 32'(ex_dst), 32'd3);
        chk("addu_valid", 32'(ex_valid), 32'd1);
        chk("tnew2", 32'(ex_tnew), 32'd1);

        load_instr(32'h3004, 32'h0022_1821, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 2'd0);
        step("tnew0");
        chk("tnew0_nowrap", 32'(ex_tnew), 32'd0);

        // MEM over WB, then WB alone; rt=0 ignores any source
        load_instr(32'h3008, 32'h1, 5'd5, 5'd0, 5'd9, 32'h55, 32'h66, 2'd1);
        step("ld_rs5");
        m_we = 1; m_addr = 5; m_data = 32'hAAAA; w_we = 1; w_addr = 5; w_data = 32'hBBBB;
        #1;
        chk("fwd_mem_prio", ex_rs_val, 32'hAAAA);
        m_we = 0;
        #1;
        chk("fwd_wb", ex_rs_val, 32'hBBBB);
        m_we = 1; m_addr = 0; m_data = 32'h1234; w_we = 0;
        #1;
        chk("fwd_r0", ex_rt_val, 32'h0);
        clear_in();

        // hold three cycles, WB write to $7 on the second
        @(negedge clk);
        load_instr(32'h4000, 32'h2, 5'd7, 5'd8, 5'd4, 32'h7777, 32'h8888, 2'd1);
        step("ld_rs7");
        clear_in();
        hold_i = 1; id_valid = 1; id_pc = 32'hDEAD; id_instr = 32'hBEEF;
        step("hold1");
        w_we = 1; w_addr = 7; w_data = 32'hCAFE;
        #1;
        chk("hold_wb_same_cycle", ex_rs_val, 32'hCAFE);
        step("hold2");
        w_we = 0;
        step("hold3");
        chk("hold_refresh", ex_rs_val, 32'hCAFE);
        chk("hold_pc", ex_pc, 32'h4000);
        chk("hold_instr", ex_instr, 32'h2);

        // flush beats hold; bubble alone gives the same NOP
        flush_i = 1;
        step("flush_hold");
        chk("flush_valid", 32'(ex_valid), 32'd0);
        chk("flush_instr", ex_instr, 32'd0);
        clear_in();
        load_instr(32'h5000, 32'h3, 5'd2, 5'd3, 5'd6, 32'h1, 32'h2, 2'd2);
        step("ld_pre_bubble");
        bubble_i = 1;
        step("bubble");
        chk("bubble_dst", 32'(ex_dst), 32'd0);

        // async reset while held: contents gone, nothing replayed
        clear_in();
        load_instr(32'h6000, 32'h4, 5'd1, 5'd1, 5'd2, 32'h9, 32'h9, 2'd3);
        step("ld_pre_rst");
        hold_i = 1;
        #2;
        reset = 0;
        model_clear();
        #1;
        check_all("async_rst");
        @(negedge clk);
        reset = 1;
        step("post_rst_hold");
        chk("post_rst_pc", ex_pc, 32'd0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            hold_i   = ($urandom_range(0, 99) < 20);
            bubble_i = ($urandom_range(0, 99) < 10);
            flush_i  = ($urandom_range(0, 99) < 5);
            id_valid = $urandom_range(0, 1) == 1;
            id_pc = $urandom; id_instr = $urandom; id_imm = $urandom;
            id_rd1 = $urandom; id_rd2 = $urandom;
            id_rs = 5'($urandom_range(0, 7)); id_rt = 5'($urandom_range(0, 7));
            id_dst = 5'($urandom_range(0, 31)); id_tnew = 2'($urandom_range(0, 3));
            m_we = $urandom_range(0, 1) == 1; m_addr = 5'($urandom_range(0, 7)); m_data = $urandom;
            w_we = $urandom_range(0, 1) == 1; w_addr = 5'($urandom_range(0, 7)); w_data = $urandom;
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
